// File: rtl/instr_fetch_unit_pkg.sv
// Shared defaults for the instruction fetch unit: address/data widths,
// prefetch depth and reset vector. FIFO entries are laid out as {addr, data}.
package instr_fetch_unit_pkg;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_FIFO_DEPTH   = 2;
    localparam int DEF_RESET_VECTOR = 0;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO. Flush beats push/pop; push and pop may coincide at any
// occupancy, including full. Head reads as zero while the FIFO is empty.
module instr_fetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and prefetch stage in front of a registered-read program ROM.
// Issues one fetch per cycle while FIFO credit allows; branches flush and redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                    FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] tag;
    logic                  inflight;
    logic                  pop;
    logic                  issue;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic [EW-1:0]         head;

    assign pop = out_valid & out_ready;

    // Credit: entries held plus the byte already on its way back, minus this cycle's pop.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = occupancy < (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_VECTOR;
            tag      <= '0;
            inflight <= 1'b0;
        end else if (branch_valid) begin
            pc       <= branch_target;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + ADDR_WIDTH'(1);
            tag      <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    assign rom_addr = pc;

    instr_fetch_unit_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(EW),
        .CW   (CW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .pop       (pop),
        .flush     (branch_valid),
        .din       ({tag, rom_data}),
        .head      (head),
        .head_valid(out_valid),
        .count     (count)
    );

    assign {out_addr, out_data} = head;

endmodule
